// File: rtl/reset_sequencer.sv
// rtl/reset_sequencer.sv - power-on reset sequencer: synchronized reset/lock inputs,
// hold period, wait for PLL lock, then staggered per-domain reset release.
module reset_sequencer #(
    parameter int N_DOM       = 4,
    parameter int HOLD_CYCLES = 8,
    parameter int GAP_CYCLES  = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             async_reset_n,
    input  logic             pll_lock,
    input  logic             sw_rst_req,
    output logic [N_DOM-1:0] dom_rst_n,
    output logic             seq_done,
    output logic             lock_lost,
    output logic [1:0]       state_o
);

    localparam int              K_W       = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);
    localparam logic [K_W-1:0]   K_LAST    = K_W'(N_DOM - 1);

    typedef enum logic [1:0] {
        HOLD      = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_t;

    logic             rst_meta_n;
    logic             rst_sync_n;
    logic             lock_meta;
    logic             pll_lock_s;
    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [K_W-1:0]   k;

    // Assert immediately, release two edges after async_reset_n rises.
    always_ff @(posedge clk or negedge async_reset_n) begin
        if (!async_reset_n) begin
            rst_meta_n <= 1'b0;
            rst_sync_n <= 1'b0;
        end else begin
            rst_meta_n <= 1'b1;
            rst_sync_n <= rst_meta_n;
        end
    end

    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            lock_meta  <= 1'b0;
            pll_lock_s <= 1'b0;
        end else begin
            lock_meta  <= pll_lock;
            pll_lock_s <= lock_meta;
        end
    end

    // Software request outranks lock loss so a deliberate reset never reports lock_lost.
    always_ff @(posedge clk or negedge rst_sync_n) begin
        if (!rst_sync_n) begin
            state     <= HOLD;
            cnt       <= '0;
            k         <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            lock_lost <= 1'b0;
        end else if (sw_rst_req) begin
            state     <= HOLD;
            cnt       <= '0;
            k         <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            lock_lost <= 1'b0;
        end else if ((state == RELEASE || state == DONE) && !pll_lock_s) begin
            state     <= HOLD;
            cnt       <= '0;
            k         <= '0;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            lock_lost <= 1'b1;
        end else begin
            case (state)
                HOLD: begin
                    if (cnt >= HOLD_LAST) begin
                        state <= WAIT_LOCK;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT_LOCK: begin
                    if (pll_lock_s) begin
                        state <= RELEASE;
                        cnt   <= '0;
                        k     <= '0;
                    end
                end
                RELEASE: begin
                    if (cnt >= GAP_LAST) begin
                        dom_rst_n <= dom_rst_n | (N_DOM'(1) << k);
                        cnt       <= '0;
                        if (k >= K_LAST) begin
                            state    <= DONE;
                            seq_done <= 1'b1;
                        end else begin
                            k <= k + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

    assign state_o = state;

endmodule

// File: tb/tb_reset_sequencer.sv
// tb/tb_reset_sequencer.sv - directed table-driven bench for reset_sequencer.
module tb_reset_sequencer;

    logic       clk = 1'b0;
    logic       async_reset_n;
    logic       pll_lock;
    logic       sw_rst_req;
    logic [3:0] dom_rst_n;
    logic       seq_done;
    logic       lock_lost;
    logic [1:0] state_o;

    int n_vec = 0;
    int n_bad = 0;

    typedef struct {
        int         cyc;
        bit         sw;
        bit         lock;
        logic [3:0] dom;
        bit         done;
        bit         lost;
        logic [1:0] st;
    } vec_t;

    vec_t tbl[$];

    reset_sequencer dut (
        .clk          (clk),
        .async_reset_n(async_reset_n),
        .pll_lock     (pll_lock),
        .sw_rst_req   (sw_rst_req),
        .dom_rst_n    (dom_rst_n),
        .seq_done     (seq_done),
        .lock_lost    (lock_lost),
        .state_o      (state_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] dom_e, input bit done_e,
                         input bit lost_e, input logic [1:0] st_e);
        n_vec++;
        if (dom_rst_n !== dom_e || seq_done !== done_e || lock_lost !== lost_e || state_o !== st_e) begin
            n_bad++;
            $display("FAIL %s: got dom=%b done=%b lost=%b st=%0d, want dom=%b done=%b lost=%b st=%0d",
                     name, dom_rst_n, seq_done, lock_lost, state_o, dom_e, done_e, lost_e, st_e);
        end
    endtask

    task automatic check_sync(input string name, input logic exp);
        n_vec++;
        if (dut.rst_sync_n !== exp) begin
            n_bad++;
            $display("FAIL %s: rst_sync_n got %b want %b", name, dut.rst_sync_n, exp);
        end
    endtask

    function automatic void add(input int cyc, input bit sw, input bit lock, input logic [3:0] dom,
                                input bit done, input bit lost, input logic [1:0] st);
        vec_t v;
        v.cyc = cyc; v.sw = sw; v.lock = lock; v.dom = dom;
        v.done = done; v.lost = lost; v.st = st;
        tbl.push_back(v);
    endfunction

    // sw is asserted for the first edge of a step only.
    task automatic run_range(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            pll_lock   = tbl[i].lock;
            sw_rst_req = tbl[i].sw;
            for (int c = 0; c < tbl[i].cyc; c++) begin
                tick();
                sw_rst_req = 1'b0;
            end
            check($sformatf("vec%0d", i), tbl[i].dom, tbl[i].done, tbl[i].lost, tbl[i].st);
        end
    endtask

    initial begin
        // Normal bring-up: HOLD 8, WAIT_LOCK 1, releases every 4 cycles.
        add(7, 0, 1, 4'b0000, 0, 0, 2'd0);   // 0
        add(1, 0, 1, 4'b0000, 0, 0, 2'd1);   // 1
        add(1, 0, 1, 4'b0000, 0, 0, 2'd2);   // 2
        add(3, 0, 1, 4'b0000, 0, 0, 2'd2);   // 3
        add(1, 0, 1, 4'b0001, 0, 0, 2'd2);   // 4
        add(4, 0, 1, 4'b0011, 0, 0, 2'd2);   // 5
        add(4, 0, 1, 4'b0111, 0, 0, 2'd2);   // 6
        add(3, 0, 1, 4'b0111, 0, 0, 2'd2);   // 7
        add(1, 0, 1, 4'b1111, 1, 0, 2'd3);   // 8
        // Lock loss in DONE, long wait for relock, resequence with sticky lock_lost.
        add(2, 0, 0, 4'b1111, 1, 0, 2'd3);   // 9
        add(1, 0, 0, 4'b0000, 0, 1, 2'd0);   // 10
        add(7, 0, 0, 4'b0000, 0, 1, 2'd0);   // 11
        add(1, 0, 0, 4'b0000, 0, 1, 2'd1);   // 12
        add(20, 0, 0, 4'b0000, 0, 1, 2'd1);  // 13
        add(2, 0, 1, 4'b0000, 0, 1, 2'd1);   // 14
        add(1, 0, 1, 4'b0000, 0, 1, 2'd2);   // 15
        add(4, 0, 1, 4'b0001, 0, 1, 2'd2);   // 16
        add(4, 0, 1, 4'b0011, 0, 1, 2'd2);   // 17
        // Software reset at 0011, fresh hold, release restarts at bit 0.
        add(1, 1, 1, 4'b0000, 0, 0, 2'd0);   // 18
        add(7, 0, 1, 4'b0000, 0, 0, 2'd0);   // 19
        add(1, 0, 1, 4'b0000, 0, 0, 2'd1);   // 20
        add(1, 0, 1, 4'b0000, 0, 0, 2'd2);   // 21
        add(4, 0, 1, 4'b0001, 0, 0, 2'd2);   // 22
        // Software reset mid-HOLD restarts the hold count.
        add(1, 1, 1, 4'b0000, 0, 0, 2'd0);   // 23
        add(5, 0, 1, 4'b0000, 0, 0, 2'd0);   // 24
        add(1, 1, 1, 4'b0000, 0, 0, 2'd0);   // 25
        add(7, 0, 1, 4'b0000, 0, 0, 2'd0);   // 26
        add(1, 0, 1, 4'b0000, 0, 0, 2'd1);   // 27
        add(1, 0, 1, 4'b0000, 0, 0, 2'd2);   // 28
        // Lock loss and software reset on the same edge.
        add(2, 0, 0, 4'b0000, 0, 0, 2'd2);   // 29
        add(1, 1, 0, 4'b0000, 0, 0, 2'd0);   // 30
        add(8, 0, 1, 4'b0000, 0, 0, 2'd1);   // 31
        add(1, 0, 1, 4'b0000, 0, 0, 2'd2);   // 32
        add(4, 0, 1, 4'b0001, 0, 0, 2'd2);   // 33
        add(4, 0, 1, 4'b0011, 0, 0, 2'd2);   // 34

        async_reset_n = 1'b0;
        pll_lock      = 1'b1;
        sw_rst_req    = 1'b0;
        repeat (3) tick();
        check("reset_state", 4'b0000, 0, 0, 2'd0);
        check_sync("sync_in_reset", 1'b0);

        async_reset_n = 1'b1;
        tick();
        check_sync("sync_edge1", 1'b0);
        tick();
        check_sync("sync_edge2", 1'b1);
        run_range(0, 34);

        // Asynchronous assertion mid-RELEASE clears outputs with no clock edge.
        #3;
        async_reset_n = 1'b0;
        #1;
        check("async_clear", 4'b0000, 0, 0, 2'd0);
        check_sync("async_sync_low", 1'b0);
        repeat (2) tick();
        check("async_held", 4'b0000, 0, 0, 2'd0);

        async_reset_n = 1'b1;
        tick();
        check_sync("resync_edge1", 1'b0);
        tick();
        check_sync("resync_edge2", 1'b1);
        run_range(0, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
